// File: rtl/pc_parser_pkg.sv
// Shared definitions for the PC word parser: default widths, field offsets
// and the word classification used by both the parser and the config stage.
package pc_parser_pkg;

  localparam int NPCIN_DEFAULT   = 24;
  localparam int NBDDATA_DEFAULT = 21;
  localparam int NCONF_DEFAULT   = 16;
  localparam int NREG_DEFAULT    = 32;
  localparam int NCHAN_DEFAULT   = 8;

  // Field positions are given as offsets below the word MSB so they scale with NPCin
  localparam int TYPE_OFS = 1;
  localparam int SEL_OFS  = 2;
  localparam int ID_OFS   = 3;

  typedef enum logic [1:0] {
    BD_WORD   = 2'd0,
    REG_WORD  = 2'd1,
    CHAN_WORD = 2'd2
  } word_type_e;

  function automatic word_type_e classifyWord(input logic typeBit, input logic selBit);
    if (!typeBit) begin
      return BD_WORD;
    end
    return selBit ? CHAN_WORD : REG_WORD;
  endfunction

endpackage

// File: rtl/pc_word_decode.sv
// Combinational field extraction and classification of one host word.
module pc_word_decode
  import pc_parser_pkg::*;
#(
  parameter int NPCin   = NPCIN_DEFAULT,
  parameter int NBDdata = NBDDATA_DEFAULT,
  parameter int Nconf   = NCONF_DEFAULT
) (
  input  logic [NPCin-1:0]        word_i,
  output word_type_e              type_o,
  output logic [NPCin-3-Nconf:0]  id_o,
  output logic [Nconf-1:0]        data_o,
  output logic [NBDdata-1:0]      bdData_o
);

  localparam int Nid = NPCin - 2 - Nconf;

  assign type_o   = classifyWord(word_i[NPCin-TYPE_OFS], word_i[NPCin-SEL_OFS]);
  assign id_o     = word_i[NPCin-ID_OFS -: Nid];
  assign data_o   = word_i[Nconf-1:0];
  assign bdData_o = word_i[NBDdata-1:0];

endmodule

// File: rtl/pc_parser.sv
// First-level split of host words into BD passthrough, config register
// writes and config channel tokens.
module pc_parser
  import pc_parser_pkg::*;
#(
  parameter int NPCin   = NPCIN_DEFAULT,
  parameter int NBDdata = NBDDATA_DEFAULT,
  parameter int Nconf   = NCONF_DEFAULT,
  parameter int Nreg    = NREG_DEFAULT,
  parameter int Nchan   = NCHAN_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pc_in_v,
  input  logic [NPCin-1:0]         pc_in_d,
  output logic                     pc_in_a,
  output logic                     bd_out_v,
  output logic [NBDdata-1:0]       bd_out_d,
  input  logic                     bd_out_a,
  output logic [Nchan-1:0]         conf_chan_v,
  output logic [Nchan*Nconf-1:0]   conf_chan_d,
  input  logic [Nchan-1:0]         conf_chan_a,
  output logic [Nreg*Nconf-1:0]    conf_reg_out,
  input  logic [Nreg*Nconf-1:0]    conf_reg_reset_vals
);

  localparam int Nid = NPCin - 2 - Nconf;

  word_type_e            wordType;
  logic [Nid-1:0]        wordId;
  logic [Nconf-1:0]      wordData;
  logic [NBDdata-1:0]    bdData;
  logic [31:0]           idIndex;
  logic                  regHit;
  logic                  chanHit;
  logic                  chanAck;
  logic                  regWrite;
  logic [Nreg*Nconf-1:0] regs_q;
  logic [Nreg*Nconf-1:0] regs_d;

  pc_word_decode #(
    .NPCin  (NPCin),
    .NBDdata(NBDdata),
    .Nconf  (Nconf)
  ) u_decode (
    .word_i  (pc_in_d),
    .type_o  (wordType),
    .id_o    (wordId),
    .data_o  (wordData),
    .bdData_o(bdData)
  );

  assign idIndex = 32'(wordId);
  assign regHit  = (wordType == REG_WORD)  && (idIndex < 32'(Nreg));
  assign chanHit = (wordType == CHAN_WORD) && (idIndex < 32'(Nchan));

  always_comb begin
    chanAck = 1'b0;
    for (int i = 0; i < Nchan; i++) begin
      if (idIndex == 32'(i)) begin
        chanAck = conf_chan_a[i];
      end
    end
  end

  // Reset forces every handshake low, so nothing is consumed or forwarded
  always_comb begin
    pc_in_a     = 1'b0;
    bd_out_v    = 1'b0;
    bd_out_d    = '0;
    conf_chan_v = '0;
    conf_chan_d = '0;
    if (!reset) begin
      unique case (wordType)
        BD_WORD: begin
          bd_out_v = pc_in_v;
          bd_out_d = pc_in_v ? bdData : '0;
          pc_in_a  = bd_out_a;
        end
        REG_WORD: begin
          pc_in_a = pc_in_v;
        end
        CHAN_WORD: begin
          pc_in_a = chanHit ? chanAck : pc_in_v;
          for (int i = 0; i < Nchan; i++) begin
            if (chanHit && (idIndex == 32'(i))) begin
              conf_chan_v[i]              = pc_in_v;
              conf_chan_d[i*Nconf +: Nconf] = pc_in_v ? wordData : '0;
            end
          end
        end
        default: begin
          pc_in_a = 1'b0;
        end
      endcase
    end
  end

  assign regWrite = pc_in_v && pc_in_a && regHit;

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < Nreg; i++) begin
      if (regWrite && (idIndex == 32'(i))) begin
        regs_d[i*Nconf +: Nconf] = wordData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= conf_reg_reset_vals;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign conf_reg_out = regs_q;

endmodule

// File: tb/tb_pc_parser.sv
// Scoreboard bench for pc_parser with four registers and four channels.
module tb_pc_parser;

  localparam int NREG  = 4;
  localparam int NCHAN = 4;

  logic                  clk;
  logic                  reset;
  logic                  pc_in_v;
  logic [23:0]           pc_in_d;
  logic                  pc_in_a;
  logic                  bd_out_v;
  logic [20:0]           bd_out_d;
  logic                  bd_out_a;
  logic [NCHAN-1:0]      conf_chan_v;
  logic [NCHAN*16-1:0]   conf_chan_d;
  logic [NCHAN-1:0]      conf_chan_a;
  logic [NREG*16-1:0]    conf_reg_out;
  logic [NREG*16-1:0]    conf_reg_reset_vals;

  logic [NREG*16-1:0]    refRegs;
  logic [31:0]           expQ[$];
  int                    testsRun  = 0;
  int                    failCount = 0;
  bit                    randomSinks = 1'b0;

  pc_parser #(
    .NPCin  (24),
    .NBDdata(21),
    .Nconf  (16),
    .Nreg   (NREG),
    .Nchan  (NCHAN)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .pc_in_v            (pc_in_v),
    .pc_in_d            (pc_in_d),
    .pc_in_a            (pc_in_a),
    .bd_out_v           (bd_out_v),
    .bd_out_d           (bd_out_d),
    .bd_out_a           (bd_out_a),
    .conf_chan_v        (conf_chan_v),
    .conf_chan_d        (conf_chan_d),
    .conf_chan_a        (conf_chan_a),
    .conf_reg_out       (conf_reg_out),
    .conf_reg_reset_vals(conf_reg_reset_vals)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard entries are {destination, data}; destination 0 is BD, 1..NCHAN are channels
  task automatic pushExpected(input logic [23:0] w);
    logic [5:0] id;
    id = w[21:16];
    if (!w[23]) begin
      expQ.push_back({8'd0, 3'd0, w[20:0]});
    end else if (w[22] && (id < 6'(NCHAN))) begin
      expQ.push_back({8'(id) + 8'd1, 8'd0, w[15:0]});
    end
  endtask

  task automatic modelRegWrite(input logic [23:0] w);
    logic [5:0] id;
    id = w[21:16];
    if ((w[23:22] == 2'b10) && (id < 6'(NREG))) begin
      refRegs[int'(id)*16 +: 16] = w[15:0];
    end
  endtask

  task automatic scoreboardPop(input string name, input logic [31:0] actual);
    if (expQ.size() == 0) begin
      testsRun++;
      failCount++;
      $display("[TB] FAIL %s: unexpected transfer 0x%0h, nothing expected", name, actual);
    end else begin
      checkOutput(name, 64'(actual), 64'(expQ.pop_front()));
    end
  endtask

  // Drives one word from posedge+1 and holds it until the handshake edge
  task automatic applyStimulus(input logic [23:0] w);
    bit acked;
    int waitCycles;
    acked      = 1'b0;
    waitCycles = 0;
    pc_in_v    = 1'b1;
    pc_in_d    = w;
    pushExpected(w);
    while (!acked && waitCycles < 200) begin
      @(negedge clk);
      acked = pc_in_a;
      @(posedge clk);
      #1;
      waitCycles++;
    end
    if (!acked) begin
      testsRun++;
      failCount++;
      $display("[TB] FAIL handshake timeout: word 0x%0h never acked, expected ack within 200 cycles", w);
    end else begin
      modelRegWrite(w);
    end
    pc_in_v = 1'b0;
    pc_in_d = '0;
  endtask

  always begin
    @(posedge clk);
    #1;
    if (randomSinks) begin
      bd_out_a    = 1'($urandom_range(0, 1));
      conf_chan_a = 4'($urandom_range(0, 15));
    end
  end

  // Monitor: pops the scoreboard on every output transfer and tracks the register file
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bd_out_v && bd_out_a) begin
          scoreboardPop("bd transfer", {8'd0, 3'd0, bd_out_d});
        end
        for (int i = 0; i < NCHAN; i++) begin
          if (conf_chan_v[i] && conf_chan_a[i]) begin
            scoreboardPop("chan transfer", {8'(i + 1), 8'd0, conf_chan_d[i*16 +: 16]});
          end
        end
        if (!bd_out_v) begin
          checkOutput("bd data idle zero", 64'(bd_out_d), 64'd0);
        end
        checkOutput("single destination", 64'($countones({bd_out_v, conf_chan_v}) > 1), 64'd0);
        checkOutput("reg file", 64'(conf_reg_out), 64'(refRegs));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [23:0] w;
    logic [5:0]  idBits;
    int          kind;

    conf_reg_reset_vals = 64'h0003_0002_0001_0000;
    refRegs     = 64'h0003_0002_0001_0000;
    reset       = 1'b1;
    pc_in_v     = 1'b1;
    pc_in_d     = 24'h012345;
    bd_out_a    = 1'b1;
    conf_chan_a = 4'b1111;

    // Reset: even with a valid BD word and a ready sink, nothing may move
    @(negedge clk);
    checkOutput("reset pc_in_a", 64'(pc_in_a), 64'd0);
    checkOutput("reset bd_out_v", 64'(bd_out_v), 64'd0);
    checkOutput("reset conf_chan_v", 64'(conf_chan_v), 64'd0);
    checkOutput("reset regs", 64'(conf_reg_out), 64'h0003_0002_0001_0000);
    @(posedge clk);
    #1;
    reset       = 1'b0;
    pc_in_v     = 1'b0;
    pc_in_d     = '0;
    bd_out_a    = 1'b0;
    conf_chan_a = '0;

    // Register write, acked in the same cycle
    pc_in_v = 1'b1;
    pc_in_d = 24'h82BEEF;
    @(negedge clk);
    checkOutput("reg write ack", 64'(pc_in_a), 64'd1);
    @(posedge clk);
    #1;
    pc_in_v = 1'b0;
    refRegs[47:32] = 16'hBEEF;
    checkOutput("reg2 written", 64'(conf_reg_out[47:32]), 64'hBEEF);
    checkOutput("reg0 held", 64'(conf_reg_out[15:0]), 64'h0000);

    // Out-of-range register id: acked and dropped
    applyStimulus(24'h851111);
    checkOutput("reg id5 dropped", 64'(conf_reg_out), 64'h0003_BEEF_0001_0000);

    // Channel token stalled by the sink for three cycles
    pc_in_v = 1'b1;
    pc_in_d = 24'hC11234;
    pushExpected(24'hC11234);
    repeat (3) @(negedge clk);
    checkOutput("chan stall valid", 64'(conf_chan_v), 64'b0010);
    checkOutput("chan stall data", 64'(conf_chan_d[31:16]), 64'h1234);
    checkOutput("chan other data zero", 64'({conf_chan_d[63:32], conf_chan_d[15:0]}), 64'd0);
    checkOutput("chan stall ack", 64'(pc_in_a), 64'd0);
    @(posedge clk);
    #1;
    conf_chan_a = 4'b0010;
    @(negedge clk);
    checkOutput("chan release ack", 64'(pc_in_a), 64'd1);
    @(posedge clk);
    #1;
    pc_in_v     = 1'b0;
    conf_chan_a = '0;
    checkOutput("chan single transfer", 64'(expQ.size()), 64'd0);

    // BD passthrough, ack follows the sink
    pc_in_v = 1'b1;
    pc_in_d = 24'h1ABCDE;
    pushExpected(24'h1ABCDE);
    @(negedge clk);
    checkOutput("bd valid", 64'(bd_out_v), 64'd1);
    checkOutput("bd data", 64'(bd_out_d), 64'h1ABCDE);
    checkOutput("bd ack blocked", 64'(pc_in_a), 64'd0);
    checkOutput("bd conf valids", 64'(conf_chan_v), 64'd0);
    @(posedge clk);
    #1;
    bd_out_a = 1'b1;
    @(negedge clk);
    checkOutput("bd ack follows", 64'(pc_in_a), 64'd1);
    @(posedge clk);
    #1;
    pc_in_v  = 1'b0;
    bd_out_a = 1'b0;

    // Random traffic under random back-pressure, ids straddle the valid range
    randomSinks = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      kind   = int'($urandom_range(0, 2));
      idBits = 6'($urandom_range(0, 7));
      if (kind == 0) begin
        w = {1'b0, 23'($urandom)};
      end else if (kind == 1) begin
        w = {2'b10, idBits, 16'($urandom)};
      end else begin
        w = {2'b11, idBits, 16'($urandom)};
      end
      applyStimulus(w);
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
    end
    randomSinks = 1'b0;
    @(posedge clk);
    #1;
    bd_out_a    = 1'b0;
    conf_chan_a = '0;

    // Reset arriving with a register word in flight must not write it
    applyStimulus(24'h805555);
    reset   = 1'b1;
    pc_in_v = 1'b1;
    pc_in_d = 24'h80AAAA;
    @(negedge clk);
    checkOutput("mid reset ack", 64'(pc_in_a), 64'd0);
    @(posedge clk);
    #1;
    refRegs = conf_reg_reset_vals;
    checkOutput("mid reset reg0", 64'(conf_reg_out[15:0]), 64'h0000);
    reset   = 1'b0;
    pc_in_v = 1'b0;
    pc_in_d = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
